// File: rtl/cfg_pkg.sv
// Shared definitions for the configuration frame writer.
//   state_e         - FSM state encoding (IDLE, LOAD, DRAIN, COMMIT).
//   calc_nwords()   - stream words needed to cover a configuration word.
//   calc_cnt_w()    - word counter width for a given frame length.
//   CNT_W           - counter width for the default 384-bit / 8-bit setup.
package cfg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_COMMIT = 2'd3
  } state_e;

  function automatic int calc_nwords(input int conf_width, input int din_w);
    return (conf_width + din_w - 1) / din_w;
  endfunction

  // The counter must be able to hold NWORDS itself, so it never wraps
  // inside a frame.
  function automatic int calc_cnt_w(input int nwords);
    return $clog2(nwords + 1);
  endfunction

  localparam int DEF_CONF_WIDTH = 16 * (8 + 16);
  localparam int DEF_DIN_W      = 8;
  localparam int CNT_W          = calc_cnt_w(calc_nwords(DEF_CONF_WIDTH, DEF_DIN_W));

endpackage

// File: rtl/config_frame_writer_if.sv
// Byte-wide configuration stream (valid/ready handshake).
//   cfg_valid - producer has a word
//   cfg_ready - consumer accepts; transfer when valid & ready at clk edge
//   cfg_data  - stream word (DIN_W bits)
//   cfg_last  - final word of a frame
// master: stream producer; slave: the frame writer.
interface config_frame_writer_if #(
  parameter int DIN_W = 8
);
  logic             cfg_valid;
  logic             cfg_ready;
  logic [DIN_W-1:0] cfg_data;
  logic             cfg_last;

  modport master (output cfg_valid, output cfg_data, output cfg_last, input cfg_ready);
  modport slave  (input cfg_valid, input cfg_data, input cfg_last, output cfg_ready);
endinterface

// File: rtl/config_frame_writer.sv
// Configuration frame writer: assembles a byte stream into the wide fabric
// configuration word and commits it with a one-cycle strobe.
//   clk   - clock, rising edge
//   rst   - asynchronous, active-low reset
//   cfg   - stream slave port (valid/ready/data/last)
//   c     - committed configuration word, holds between commits
//   cset  - one-cycle commit strobe, c is valid while it is high
//   busy  - FSM is not idle
//   err   - sticky frame error, cleared by the next frame's first word
// Only frames of exactly NWORDS words terminated by cfg_last reach c;
// short frames are dropped, oversized frames are drained to cfg_last.
module config_frame_writer
  import cfg_pkg::*;
#(
  parameter  int W          = 16,
  parameter  int DATAIN     = 8,
  parameter  int DATAOUT    = 16,
  parameter  int DIN_W      = 8,
  localparam int CONF_WIDTH = W * (DATAIN + DATAOUT)
) (
  input  logic                    clk,
  input  logic                    rst,
  config_frame_writer_if.slave    cfg,
  output logic [CONF_WIDTH-1:0]   c,
  output logic                    cset,
  output logic                    busy,
  output logic                    err
);

  localparam int NWORDS = calc_nwords(CONF_WIDTH, DIN_W);
  localparam int CW     = calc_cnt_w(NWORDS);
  localparam int SH_W   = NWORDS * DIN_W;
  localparam logic [CW-1:0] LAST_IDX = CW'(NWORDS - 1);

  state_e                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [SH_W-1:0]         shadow_q, shadow_d;
  logic [CONF_WIDTH-1:0]   c_q, c_d;
  logic                    cset_q, cset_d;
  logic                    err_q, err_d;
  logic                    ready_q, ready_d;
  logic                    accept;

  assign accept        = cfg.cfg_valid & ready_q;
  assign cfg.cfg_ready = ready_q;
  assign c             = c_q;
  assign cset          = cset_q;
  assign err           = err_q;
  assign busy          = (state_q != ST_IDLE);

  // NOTE: every variable gets its default before the case statement so no
  // path leaves one unassigned; that is what keeps this block latch-free.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    err_d    = err_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          err_d                = 1'b0;
          shadow_d[DIN_W-1:0]  = cfg.cfg_data;
          cnt_d                = CW'(1);
          if (!cfg.cfg_last)    state_d = ST_LOAD;
          else if (NWORDS == 1) state_d = ST_COMMIT;
          else                  err_d   = 1'b1;   // one-word frame is short
        end
      end

      ST_LOAD: begin
        if (accept) begin
          // Shadow write decoder: word k lands at bits [k*DIN_W +: DIN_W].
          for (int k = 0; k < NWORDS; k++) begin
            if (cnt_q == CW'(k)) shadow_d[k*DIN_W +: DIN_W] = cfg.cfg_data;
          end
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == LAST_IDX) begin
            if (cfg.cfg_last) begin
              state_d = ST_COMMIT;
            end else begin
              state_d = ST_DRAIN;                  // oversized frame
              err_d   = 1'b1;
            end
          end else if (cfg.cfg_last) begin
            state_d = ST_IDLE;                     // short frame
            err_d   = 1'b1;
          end
        end
      end

      ST_DRAIN: begin
        if (accept && cfg.cfg_last) state_d = ST_IDLE;
      end

      ST_COMMIT: state_d = ST_IDLE;

      default:   state_d = ST_IDLE;
    endcase
  end

  // Outputs are registered off the next state so c and cset change on the
  // same edge that enters COMMIT, and ready drops for the COMMIT cycle.
  assign ready_d = (state_d != ST_COMMIT);
  assign cset_d  = (state_d == ST_COMMIT);
  assign c_d     = cset_d ? shadow_d[CONF_WIDTH-1:0] : c_q;

  // NOTE: the shadow is a plain register bank, not RAM, so it is reset like
  // any flop; a reset mid-frame therefore leaves no stale bytes behind.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      shadow_q <= '0;
      c_q      <= '0;
      cset_q   <= 1'b0;
      err_q    <= 1'b0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      c_q      <= c_d;
      cset_q   <= cset_d;
      err_q    <= err_d;
      ready_q  <= ready_d;
    end
  end

endmodule

// File: tb/tb_config_frame_writer.sv
// Self-checking bench for config_frame_writer. A frame-level model (queue of
// received words) predicts c/cset/err/busy/cfg_ready every cycle; directed
// phases add literal expectations for the scenarios of interest.
module tb_config_frame_writer;

  localparam int CW = 384;
  localparam int DW = 8;
  localparam int NW = 48;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  config_frame_writer_if #(.DIN_W(DW)) cfg_if ();

  logic [CW-1:0] c;
  logic          cset, busy, err;

  config_frame_writer dut (
    .clk  (clk),
    .rst  (rst),
    .cfg  (cfg_if.slave),
    .c    (c),
    .cset (cset),
    .busy (busy),
    .err  (err)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [CW-1:0] pack(input logic [DW-1:0] w[$]);
    logic [CW-1:0] v;
    v = '0;
    for (int k = 0; k < NW; k++) v[k*DW +: DW] = w[k];
    return v;
  endfunction

  // ---------------- frame-level reference model ----------------
  logic [DW-1:0] m_q[$];
  bit            m_drain = 1'b0;
  logic [CW-1:0] m_c     = '0;
  logic          m_cset  = 1'b0;
  logic          m_err   = 1'b0;
  logic          m_ready = 1'b0;
  logic          m_busy  = 1'b0;
  bit            m_acc;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_q.delete();
      m_drain = 1'b0;
      m_c     = '0;
      m_cset  = 1'b0;
      m_err   = 1'b0;
      m_ready = 1'b0;
      m_busy  = 1'b0;
    end else begin
      m_acc   = cfg_if.cfg_valid && m_ready;
      m_cset  = 1'b0;
      m_ready = 1'b1;
      if (m_acc) begin
        if (m_drain) begin
          if (cfg_if.cfg_last) m_drain = 1'b0;
        end else begin
          if (m_q.size() == 0) m_err = 1'b0;
          m_q.push_back(cfg_if.cfg_data);
          if (cfg_if.cfg_last) begin
            if (m_q.size() == NW) begin
              m_c     = pack(m_q);
              m_cset  = 1'b1;
              m_ready = 1'b0;
            end else begin
              m_err = 1'b1;
            end
            m_q.delete();
          end else if (m_q.size() == NW) begin
            m_drain = 1'b1;
            m_err   = 1'b1;
            m_q.delete();
          end
        end
      end
      m_busy = m_drain || (m_q.size() != 0) || m_cset;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  bit chk_en = 1'b0;
  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_c",     c,                m_c);
      check("cyc_cset",  cset,             m_cset);
      check("cyc_err",   err,              m_err);
      check("cyc_busy",  busy,             m_busy);
      check("cyc_ready", cfg_if.cfg_ready, m_ready);
    end
  end

  // Downstream connection block: captures c while cset is high.
  logic [CW-1:0] c_reg = '0;
  int            cset_cnt = 0;
  always @(posedge clk) begin
    if (cset) begin
      c_reg <= c;
      cset_cnt++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic send_word(input logic [DW-1:0] d, input bit last, input int gap_pct);
    bit r;
    while ($urandom_range(99) < gap_pct) begin
      cfg_if.cfg_valid = 1'b0;
      cfg_if.cfg_data  = DW'($urandom);
      cfg_if.cfg_last  = 1'($urandom);
      @(negedge clk);
    end
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_data  = d;
    cfg_if.cfg_last  = last;
    for (int g = 0; g < 50; g++) begin
      r = cfg_if.cfg_ready;
      @(negedge clk);
      if (r) begin
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_last  = 1'b0;
        return;
      end
    end
    total++;
    bad++;
    $display("FAIL handshake: word not accepted within 50 cycles");
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_last  = 1'b0;
  endtask

  // Sends n words, cfg_last on word last_idx (-1: none). seq selects k+1 data.
  task automatic send_frame(input int n, input int last_idx, input int gap_pct,
                            input bit seq, output logic [CW-1:0] exp);
    logic [DW-1:0] w;
    exp = '0;
    for (int k = 0; k < n; k++) begin
      w = seq ? DW'(k + 1) : DW'($urandom);
      if (k < NW) exp[k*DW +: DW] = w;
      send_word(w, (k == last_idx), gap_pct);
    end
  endtask

  logic [CW-1:0] exp, prev;
  int            n0;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_data  = '0;
    cfg_if.cfg_last  = 1'b0;
    chk_en = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_c",     c,                '0);
    check("rst_cset",  cset,             1'b0);
    check("rst_ready", cfg_if.cfg_ready, 1'b0);
    check("rst_busy",  busy,             1'b0);
    check("rst_err",   err,              1'b0);
    rst = 1'b1;
    @(negedge clk);
    check("rel_ready", cfg_if.cfg_ready, 1'b1);
    check("rel_c",     c,                '0);

    // Good frame, data k+1
    n0 = cset_cnt;
    send_frame(NW, NW - 1, 0, 1'b1, exp);
    check("good_lo_byte", c[7:0],     8'h01);
    check("good_hi_byte", c[383:376], 8'h30);
    check("good_cset",    cset,       1'b1);
    check("good_c",       c,          exp);
    @(negedge clk);
    check("good_cset_off",  cset,             1'b0);
    check("good_ready_on",  cfg_if.cfg_ready, 1'b1);
    check("good_c_reg",     c_reg,            exp);
    check("good_cset_once", 32'(cset_cnt - n0), 32'd1);

    // Random data with back-pressure gaps
    for (int f = 0; f < 4; f++) begin
      n0 = cset_cnt;
      send_frame(NW, NW - 1, 30, 1'b0, exp);
      check("gap_c", c, exp);
      @(negedge clk);
      check("gap_c_reg",     c_reg,              exp);
      check("gap_cset_once", 32'(cset_cnt - n0), 32'd1);
    end

    // Short frame: last on word 20
    prev = c;
    n0   = cset_cnt;
    send_frame(21, 20, 20, 1'b0, exp);
    check("short_err", err, 1'b1);
    repeat (3) @(negedge clk);
    check("short_c",       c,                  prev);
    check("short_no_cset", 32'(cset_cnt - n0), 32'd0);
    check("short_busy",    busy,               1'b0);

    // Next good frame clears err and commits
    send_frame(NW, NW - 1, 10, 1'b0, exp);
    check("recov_err", err, 1'b0);
    check("recov_c",   c,   exp);
    @(negedge clk);

    // One-word frame is also short
    send_frame(1, 0, 0, 1'b0, exp);
    check("one_word_err", err, 1'b1);

    // Oversized frame: 52 words, last on word 51
    prev = c;
    n0   = cset_cnt;
    send_frame(52, 51, 10, 1'b0, exp);
    check("long_err",     err,                1'b1);
    check("long_busy",    busy,               1'b0);
    check("long_c",       c,                  prev);
    check("long_no_cset", 32'(cset_cnt - n0), 32'd0);

    // Asynchronous reset mid-LOAD at word 30
    n0 = cset_cnt;
    send_frame(30, -1, 10, 1'b0, exp);
    #2 rst = 1'b0;
    #1;
    check("arst_c",    c,    '0);
    check("arst_busy", busy, 1'b0);
    check("arst_cset", cset, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("arst_no_cset", 32'(cset_cnt - n0), 32'd0);
    send_frame(NW, NW - 1, 20, 1'b0, exp);
    check("arst_after_c", c, exp);
    @(negedge clk);
    check("arst_after_c_reg", c_reg, exp);

    // Random mix of good, short and long frames against the model
    for (int f = 0; f < 20; f++) begin
      int kind, n;
      kind = $urandom_range(2);
      n    = (kind == 0) ? NW : (kind == 1) ? $urandom_range(NW - 1, 1) : $urandom_range(55, NW + 1);
      send_frame(n, n - 1, 25, 1'b0, exp);
      repeat (2) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/config_frame_writer.md
Name: config_frame_writer

Overview:
- Producer side of the fabric configuration interface: turns a byte-wide configuration stream into the wide `c` word plus a one-cycle `cset` strobe that connection blocks capture into their `c_reg`.
- Sits between the chip-level configuration port and one data connection block, or a group of blocks sharing `c`/`cset`.
- Assembles a complete frame in a shadow register; only exactly-sized, well-terminated frames are committed. Partial or oversized frames are dropped and flagged.

Parameters:
- W, 16, fabric wires per side; used only to derive CONF_WIDTH.
- DATAIN, 8, number of MAC input words; used only to derive CONF_WIDTH.
- DATAOUT, 16, number of MAC output words; used only to derive CONF_WIDTH.
- CONF_WIDTH, W*(DATAIN+DATAOUT) = 384, width of the configuration word.
- DIN_W, 8, stream word width.
- NWORDS, (CONF_WIDTH+DIN_W-1)/DIN_W = 48, stream words per frame.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- cfg_valid  input  1  stream word valid.
- cfg_ready  output  1  block accepts a word; transfer happens when valid & ready at a clk edge.
- cfg_data  input  DIN_W  stream word.
- cfg_last  input  1  marks the final word of a frame.
- c  output  CONF_WIDTH  committed configuration word, registered.
- cset  output  1  one-cycle commit strobe, registered.
- busy  output  1  high in any state other than IDLE.
- err  output  1  sticky frame-error flag.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, word counter=0, shadow=0.
  - c=0, cset=0, cfg_ready=0, busy=0, err=0.
  - cfg_ready rises in the first cycle after rst deasserts.
- Word placement: accepted word k (k=0..NWORDS-1) is written to shadow bits [k*DIN_W +: DIN_W], LSB-first. Bits of the final word above CONF_WIDTH are discarded.
- State IDLE:
  - cfg_ready=1.
  - On an accepted word: clear err, write word 0, set counter=1, go to LOAD.
  - If that word has cfg_last=1 and NWORDS>1: set err and stay in IDLE (short frame).
  - If that word has cfg_last=1 and NWORDS==1: go to COMMIT.
- State LOAD:
  - cfg_ready=1.
  - On an accepted word: write it at the counter position, then increment the counter.
  - cfg_last=1 and counter==NWORDS-1: go to COMMIT.
  - cfg_last=1 and counter<NWORDS-1: set err, go to IDLE; shadow content is dropped.
  - cfg_last=0 and counter==NWORDS-1: go to DRAIN (oversize frame).
  - Missing valid leaves the state unchanged; there is no timeout.
- State DRAIN:
  - cfg_ready=1; accepted words are discarded.
  - err is set on entry.
  - On an accepted word with cfg_last=1: go to IDLE.
- State COMMIT (exactly one cycle):
  - cfg_ready=0.
  - On entry, c<=shadow and cset<=1 at the same edge, so c is already valid while cset is high.
  - Next edge: cset<=0, go to IDLE.
- Latency: last word accepted at edge N → c updated and cset=1 during cycle N+1 → cset=0 and cfg_ready=1 at cycle N+2. Frame-to-frame throughput is NWORDS+1 cycles.
- c holds its value between commits. A failed frame never changes c and never pulses cset.
- err stays set until the next frame's first accepted word.
- Reset during LOAD or DRAIN: the frame is lost, c returns to 0, and no cset is issued.
- Counter width is $clog2(NWORDS+1); it never wraps within a frame.

Decomposition:
- Package cfg_pkg holds:
  - state encoding (IDLE, LOAD, DRAIN, COMMIT; 2 bits);
  - the NWORDS derivation function;
  - the counter-width constant.
- No sub-module: the shadow write decoder, counter and FSM stay in one module.

Test Plan:
- Reset release: after rst high, cfg_ready=1 next cycle; c=0, cset=0, err=0.
- Good frame: 48 words, data word k = k+1, cfg_last on word 47 → one cycle later c[7:0]=8'h01, c[383:376]=8'h30, cset=1 for exactly one cycle. A model c_reg captures the same value.
- Back-pressure gaps: random cfg_valid deassertion mid-frame → identical c; cset fires only once.
- Short frame: cfg_last on word 20 → err=1, no cset, c unchanged. The next good frame clears err and commits.
- Long frame: 52 words with cfg_last on word 51 → DRAIN, all words accepted, err=1, no cset, then IDLE.
- Async reset mid-LOAD at word 30 → c=0, busy=0 immediately. A following full frame commits correctly with no stale data.
